// File: rtl/mips_core_pkg.sv
// ============================================================================
// Module   : mips_core_pkg
// Brief    : Shared MIPS core types: ALU control, memory access type,
//            architectural register names and the decoded-instruction record.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mips_core_pkg;

  localparam int PC_W   = `ADDR_WIDTH;
  localparam int WORD_W = `DATA_WIDTH;

  typedef enum logic [4:0] {
    ALUCTL_NOP       = 5'd0,
    ALUCTL_ADD       = 5'd1,
    ALUCTL_ADDU      = 5'd2,
    ALUCTL_SUB       = 5'd3,
    ALUCTL_SUBU      = 5'd4,
    ALUCTL_AND       = 5'd5,
    ALUCTL_OR        = 5'd6,
    ALUCTL_XOR       = 5'd7,
    ALUCTL_NOR       = 5'd8,
    ALUCTL_SLL       = 5'd9,
    ALUCTL_SRL       = 5'd10,
    ALUCTL_SRA       = 5'd11,
    ALUCTL_SLLV      = 5'd12,
    ALUCTL_SRLV      = 5'd13,
    ALUCTL_SRAV      = 5'd14,
    ALUCTL_SLT       = 5'd15,
    ALUCTL_SLTU      = 5'd16,
    ALUCTL_MTC0_PASS = 5'd17,
    ALUCTL_MTC0_FAIL = 5'd18,
    ALUCTL_MTC0_DONE = 5'd19,
    ALUCTL_BA_BEQ    = 5'd20,
    ALUCTL_BA_BNE    = 5'd21,
    ALUCTL_BA_BLEZ   = 5'd22,
    ALUCTL_BA_BGTZ   = 5'd23,
    ALUCTL_BA_BGEZ   = 5'd24,
    ALUCTL_BA_BLTZ   = 5'd25
  } AluCtl;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } MemAccessType;

  typedef enum logic [4:0] {
    REG_ZERO = 5'd0,
    REG_T0   = 5'd8,
    REG_SP   = 5'd29,
    REG_RA   = 5'd31
  } MipsReg;

  typedef struct packed {
    AluCtl             alu_ctl;
    logic              is_branch;
    logic              is_jump;
    logic              is_jump_reg;
    logic [PC_W-1:0]   branch_target;
    logic              is_mem_access;
    MemAccessType      mem_action;
    logic              uses_rs;
    logic [4:0]        rs_addr;
    logic              uses_rt;
    logic [4:0]        rt_addr;
    logic              uses_immediate;
    logic [WORD_W-1:0] immediate;
    logic              uses_rw;
    logic [4:0]        rw_addr;
  } DecodedInst;

  localparam DecodedInst DECODE_NOP = '0;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [4:0] COP0_MT = 5'b00100;

  function automatic logic [WORD_W-1:0] sext16(input logic [15:0] v);
    return WORD_W'({{16{v[15]}}, v});
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_decode.sv
// ============================================================================
// Module   : inst_decode
// Brief    : Purely combinational MIPS decoder, (pc, inst) -> DecodedInst.
//            Unsupported encodings yield DECODE_NOP with illegal = 1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_decode
  import mips_core_pkg::*;
(
  input  logic [PC_W-1:0]   pc,
  input  logic [WORD_W-1:0] inst,
  output DecodedInst        dec,
  output logic              illegal
);

  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [15:0]       imm16;
  logic [PC_W-1:0]   br_target;
  logic [PC_W-1:0]   j_target;
  logic [WORD_W-1:0] link_addr;
  logic              shift_op;
  logic              rrr_op;

  assign opcode = inst[31:26];
  assign rs     = inst[25:21];
  assign rt     = inst[20:16];
  assign rd     = inst[15:11];
  assign shamt  = inst[10:6];
  assign funct  = inst[5:0];
  assign imm16  = inst[15:0];

  // Relative branch target wraps within the PC width
  assign br_target = pc + PC_W'(4) + PC_W'({{14{imm16[15]}}, imm16, 2'b00});
  assign j_target  = {inst[PC_W-3:0], 2'b00};
  assign link_addr = WORD_W'(pc) + WORD_W'(8);

  // Field decode; illegal encodings collapse to the NOP record at the end
  always_comb begin
    dec         = DECODE_NOP;
    illegal     = 1'b0;
    shift_op    = 1'b0;
    rrr_op      = 1'b0;
    dec.rs_addr = rs;
    dec.rt_addr = rt;

    case (opcode)
      OP_SPECIAL: begin
        dec.uses_rw = 1'b1;
        dec.rw_addr = rd;
        case (funct)
          FN_SLL:  begin dec.alu_ctl = ALUCTL_SLL;  shift_op = 1'b1; end
          FN_SRL:  begin dec.alu_ctl = ALUCTL_SRL;  shift_op = 1'b1; end
          FN_SRA:  begin dec.alu_ctl = ALUCTL_SRA;  shift_op = 1'b1; end
          FN_SLLV: begin dec.alu_ctl = ALUCTL_SLLV; rrr_op = 1'b1; end
          FN_SRLV: begin dec.alu_ctl = ALUCTL_SRLV; rrr_op = 1'b1; end
          FN_SRAV: begin dec.alu_ctl = ALUCTL_SRAV; rrr_op = 1'b1; end
          FN_ADD:  begin dec.alu_ctl = ALUCTL_ADD;  rrr_op = 1'b1; end
          FN_ADDU: begin dec.alu_ctl = ALUCTL_ADDU; rrr_op = 1'b1; end
          FN_SUB:  begin dec.alu_ctl = ALUCTL_SUB;  rrr_op = 1'b1; end
          FN_SUBU: begin dec.alu_ctl = ALUCTL_SUBU; rrr_op = 1'b1; end
          FN_AND:  begin dec.alu_ctl = ALUCTL_AND;  rrr_op = 1'b1; end
          FN_OR:   begin dec.alu_ctl = ALUCTL_OR;   rrr_op = 1'b1; end
          FN_XOR:  begin dec.alu_ctl = ALUCTL_XOR;  rrr_op = 1'b1; end
          FN_NOR:  begin dec.alu_ctl = ALUCTL_NOR;  rrr_op = 1'b1; end
          FN_SLT:  begin dec.alu_ctl = ALUCTL_SLT;  rrr_op = 1'b1; end
          FN_SLTU: begin dec.alu_ctl = ALUCTL_SLTU; rrr_op = 1'b1; end
          FN_JR: begin
            dec.is_jump_reg = 1'b1;
            dec.uses_rs     = 1'b1;
            dec.uses_rw     = 1'b0;
            dec.rw_addr     = 5'd0;
          end
          FN_JALR: begin
            dec.is_jump_reg    = 1'b1;
            dec.uses_rs        = 1'b1;
            dec.alu_ctl        = ALUCTL_OR;
            dec.rw_addr        = REG_RA;
            dec.uses_immediate = 1'b1;
            dec.immediate      = link_addr;
          end
          default: illegal = 1'b1;
        endcase
        // Constant shifts read their source through the rs port
        if (shift_op) begin
          dec.uses_rs        = 1'b1;
          dec.rs_addr        = rt;
          dec.uses_immediate = 1'b1;
          dec.immediate      = WORD_W'(shamt);
        end
        if (rrr_op) begin
          dec.uses_rs = 1'b1;
          dec.uses_rt = 1'b1;
        end
      end

      OP_REGIMM: begin
        dec.alu_ctl       = rt[0] ? ALUCTL_BA_BGEZ : ALUCTL_BA_BLTZ;
        dec.is_branch     = 1'b1;
        dec.uses_rs       = 1'b1;
        dec.branch_target = br_target;
      end

      OP_BEQ, OP_BNE: begin
        dec.alu_ctl       = (opcode == OP_BEQ) ? ALUCTL_BA_BEQ : ALUCTL_BA_BNE;
        dec.is_branch     = 1'b1;
        dec.uses_rs       = 1'b1;
        dec.uses_rt       = 1'b1;
        dec.branch_target = br_target;
      end

      OP_BLEZ, OP_BGTZ: begin
        dec.alu_ctl       = (opcode == OP_BLEZ) ? ALUCTL_BA_BLEZ : ALUCTL_BA_BGTZ;
        dec.is_branch     = 1'b1;
        dec.uses_rs       = 1'b1;
        dec.branch_target = br_target;
      end

      OP_J: begin
        dec.is_jump       = 1'b1;
        dec.branch_target = j_target;
      end

      OP_JAL: begin
        dec.is_jump        = 1'b1;
        dec.branch_target  = j_target;
        dec.alu_ctl        = ALUCTL_OR;
        dec.uses_rw        = 1'b1;
        dec.rw_addr        = REG_RA;
        dec.uses_immediate = 1'b1;
        dec.immediate      = link_addr;
      end

      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        dec.uses_rs        = 1'b1;
        dec.uses_immediate = 1'b1;
        dec.uses_rw        = 1'b1;
        dec.rw_addr        = rt;
        dec.immediate      = sext16(imm16);
        case (opcode)
          OP_ADDI:  dec.alu_ctl = ALUCTL_ADD;
          OP_ADDIU: dec.alu_ctl = ALUCTL_ADDU;
          OP_SLTI:  dec.alu_ctl = ALUCTL_SLT;
          OP_SLTIU: dec.alu_ctl = ALUCTL_SLTU;
          OP_ANDI:  begin dec.alu_ctl = ALUCTL_AND; dec.immediate = WORD_W'(imm16); end
          OP_ORI:   begin dec.alu_ctl = ALUCTL_OR;  dec.immediate = WORD_W'(imm16); end
          OP_XORI:  begin dec.alu_ctl = ALUCTL_XOR; dec.immediate = WORD_W'(imm16); end
          default:  begin dec.alu_ctl = ALUCTL_OR;  dec.immediate = WORD_W'({imm16, 16'h0000}); end
        endcase
      end

      OP_LW, OP_SW: begin
        dec.alu_ctl        = ALUCTL_ADD;
        dec.is_mem_access  = 1'b1;
        dec.uses_rs        = 1'b1;
        dec.uses_immediate = 1'b1;
        dec.immediate      = sext16(imm16);
        if (opcode == OP_LW) begin
          dec.mem_action = MEM_READ;
          dec.uses_rw    = 1'b1;
          dec.rw_addr    = rt;
        end else begin
          dec.mem_action = MEM_WRITE;
          dec.uses_rt    = 1'b1;
        end
      end

      OP_COP0: begin
        dec.uses_rt = 1'b1;
        if (rs != COP0_MT) begin
          illegal = 1'b1;
        end else begin
          case (rd)
            5'd23:   dec.alu_ctl = ALUCTL_MTC0_PASS;
            5'd24:   dec.alu_ctl = ALUCTL_MTC0_FAIL;
            5'd25:   dec.alu_ctl = ALUCTL_MTC0_DONE;
            default: illegal = 1'b1;
          endcase
        end
      end

      default: illegal = 1'b1;
    endcase

    // $zero is never a real dependency or destination
    if (illegal) begin
      dec = DECODE_NOP;
    end else begin
      dec.uses_rs = dec.uses_rs && (dec.rs_addr != 5'd0);
      dec.uses_rt = dec.uses_rt && (dec.rt_addr != 5'd0);
      dec.uses_rw = dec.uses_rw && (dec.rw_addr != 5'd0);
    end
  end

endmodule

`default_nettype wire

// File: rtl/decode_queue.sv
// ============================================================================
// Module   : decode_queue
// Brief    : DEPTH-entry FIFO of fetched (pc, inst) pairs presenting the
//            decoded head entry over valid/ready. Synchronous flush.
//            Optional statistics counters enabled by DECODE_QUEUE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_queue
  import mips_core_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_WIDTH-1:0]    in_pc,
  input  logic [DATA_WIDTH-1:0]    in_inst,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_WIDTH-1:0]    out_pc,
  output DecodedInst               out_dec,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
`ifdef DECODE_QUEUE_STATS_EN
  ,
  output logic [31:0]              stat_decoded,
  output logic [31:0]              stat_illegal,
  output logic [31:0]              stat_full_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic                  push;
  logic                  pop;

  // Full refuses pushes even when a pop happens in the same cycle
  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Pointer and occupancy bookkeeping; flush beats push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Entry storage needs no reset: contents are only observed when counted
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]   <= in_pc;
      inst_mem[tail] <= in_inst;
    end
  end

  assign out_pc = pc_mem[head];

  inst_decode u_inst_decode (
    .pc      (pc_mem[head]),
    .inst    (inst_mem[head]),
    .dec     (out_dec),
    .illegal (out_illegal)
  );

`ifdef DECODE_QUEUE_STATS_EN
  // Saturating usage counters; deliberately unaffected by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_decoded     <= '0;
      stat_illegal     <= '0;
      stat_full_cycles <= '0;
    end else begin
      if (pop && !out_illegal && (stat_decoded != '1))
        stat_decoded <= stat_decoded + 32'd1;
      if (pop && out_illegal && (stat_illegal != '1))
        stat_illegal <= stat_illegal + 32'd1;
      if ((count == FULL_COUNT) && (stat_full_cycles != '1))
        stat_full_cycles <= stat_full_cycles + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire
